// File: rtl/luma_convert_pipe.sv
// luma_convert_pipe
// RGB-to-grey conversion on the vid_io pixel path. Three-stage pipeline:
//   S1 registers the pixel and syncs and detects the vsync rising edge,
//   S2 forms the three weighted products plus max/min/green,
//   S3 rounds, saturates, selects by mode, aligns to OUT_W and gates by VDE.
// Data, hsync, vsync and VDE all leave exactly 3 clocks after they enter.
//
// The coefficients and mode are double-buffered. cfg_load fills a pending set.
// The pending set is promoted to the active set only on a vsync rise seen in S1.
// The pixel that carries the rise already uses the promoted set, so a frame
// never mixes weights.
//
// Streaming interface: there is no valid/ready handshake. A beat is accepted
// on every clock, and vid_pVDE_* marks which beats are active pixels.
//
// Optional build macro: LUMA_BINARIZE_EN. When defined, the port cfg_thresh is
// added and the output becomes all-ones/zero against that threshold.
module luma_convert_pipe #(
  parameter int CH_W       = 8,
  parameter int COEF_W     = 9,
  parameter int FRAC_W     = 8,
  parameter int OUT_W      = 8,
  parameter int COEF_R_RST = 77,
  parameter int COEF_G_RST = 150,
  parameter int COEF_B_RST = 29
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3*CH_W-1:0]   vid_pData_i,
  input  logic                vid_pHSync_i,
  input  logic                vid_pVSync_i,
  input  logic                vid_pVDE_i,
  output logic [OUT_W-1:0]    vid_pData_o,
  output logic                vid_pHSync_o,
  output logic                vid_pVSync_o,
  output logic                vid_pVDE_o,
  input  logic [COEF_W-1:0]   cfg_coef_r,
  input  logic [COEF_W-1:0]   cfg_coef_g,
  input  logic [COEF_W-1:0]   cfg_coef_b,
  input  logic [1:0]          cfg_mode,
  input  logic                cfg_load,
`ifdef LUMA_BINARIZE_EN
  input  logic [OUT_W-1:0]    cfg_thresh,
`endif
  input  logic                sw_reset,
  output logic                coef_pending,
  output logic [15:0]         frame_cnt
);

  localparam int PROD_W = CH_W + COEF_W;
  localparam int SUM_W  = CH_W + COEF_W + 2;

  localparam logic [1:0] MODE_LUMA  = 2'b00;
  localparam logic [1:0] MODE_MAX   = 2'b01;
  localparam logic [1:0] MODE_MIN   = 2'b10;
  localparam logic [1:0] MODE_GREEN = 2'b11;

  // Rounding constant (half an LSB of the result) and the saturation ceiling.
  // Both are one bit wider than the sum so the rounding add cannot overflow.
  localparam logic [SUM_W:0] RND   = (SUM_W+1)'(1) << (FRAC_W - 1);
  localparam logic [SUM_W:0] Y_MAX = (SUM_W+1)'((1 << CH_W) - 1);

  localparam logic [COEF_W-1:0] R_RST = COEF_W'(COEF_R_RST);
  localparam logic [COEF_W-1:0] G_RST = COEF_W'(COEF_G_RST);
  localparam logic [COEF_W-1:0] B_RST = COEF_W'(COEF_B_RST);

  // ---------------------------------------------------------------------------
  // Configuration sets
  // ---------------------------------------------------------------------------
  logic [COEF_W-1:0] act_r, act_g, act_b;
  logic [COEF_W-1:0] pend_r, pend_g, pend_b;
  logic [1:0]        act_mode, pend_mode;

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] s1_r, s1_g, s1_b;
  logic            s1_hs, s1_vs, s1_de;
  logic            s1_vs_d;

  // Frame-start detection and the set that the S1 pixel will use
  logic              vs_rise;
  logic              apply_pend;
  logic [COEF_W-1:0] eff_r, eff_g, eff_b;
  logic [1:0]        eff_mode;

  assign vs_rise    = s1_vs & ~s1_vs_d;
  assign apply_pend = vs_rise & coef_pending;
  assign eff_r      = apply_pend ? pend_r    : act_r;
  assign eff_g      = apply_pend ? pend_g    : act_g;
  assign eff_b      = apply_pend ? pend_b    : act_b;
  assign eff_mode   = apply_pend ? pend_mode : act_mode;

  // Stage 1 reductions, registered into S2
  logic [CH_W-1:0] max_c, min_c;

  // ---------------------------------------------------------------------------
  // Stage 2 registers
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] s2_prod_r, s2_prod_g, s2_prod_b;
  logic [CH_W-1:0]   s2_max, s2_min, s2_green;
  logic [1:0]        s2_mode;
  logic              s2_hs, s2_vs, s2_de;

  // Stage 3 combinational path
  logic [SUM_W-1:0]  sum_c;
  logic [SUM_W:0]    sum_rnd;
  logic [SUM_W:0]    y_full;
  logic [CH_W-1:0]   y_sat;
  logic [CH_W-1:0]   sel_c;
  logic [OUT_W-1:0]  aligned_c;
  logic [OUT_W-1:0]  result_c;

  // Pending/active configuration, frame counter and the pending flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_r        <= R_RST;
      act_g        <= G_RST;
      act_b        <= B_RST;
      act_mode     <= MODE_LUMA;
      pend_r       <= R_RST;
      pend_g       <= G_RST;
      pend_b       <= B_RST;
      pend_mode    <= MODE_LUMA;
      coef_pending <= 1'b0;
      frame_cnt    <= 16'd0;
    end else if (sw_reset) begin
      act_r        <= R_RST;
      act_g        <= G_RST;
      act_b        <= B_RST;
      act_mode     <= MODE_LUMA;
      pend_r       <= R_RST;
      pend_g       <= G_RST;
      pend_b       <= B_RST;
      pend_mode    <= MODE_LUMA;
      coef_pending <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      if (vs_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      // The edge promotes the pending contents as they were before any load
      // in this same cycle. A coincident load then refills the pending set.
      if (apply_pend) begin
        act_r    <= pend_r;
        act_g    <= pend_g;
        act_b    <= pend_b;
        act_mode <= pend_mode;
      end
      if (cfg_load) begin
        pend_r       <= cfg_coef_r;
        pend_g       <= cfg_coef_g;
        pend_b       <= cfg_coef_b;
        pend_mode    <= cfg_mode;
        coef_pending <= 1'b1;
      end else if (apply_pend) begin
        coef_pending <= 1'b0;
      end
    end
  end

  // S1: capture the pixel and syncs, and keep last vsync for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r    <= '0;
      s1_g    <= '0;
      s1_b    <= '0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_vs_d <= 1'b0;
    end else if (sw_reset) begin
      s1_r    <= '0;
      s1_g    <= '0;
      s1_b    <= '0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_vs_d <= 1'b0;
    end else begin
      s1_r    <= vid_pData_i[3*CH_W-1:2*CH_W];
      s1_g    <= vid_pData_i[2*CH_W-1:CH_W];
      s1_b    <= vid_pData_i[CH_W-1:0];
      s1_hs   <= vid_pHSync_i;
      s1_vs   <= vid_pVSync_i;
      s1_de   <= vid_pVDE_i;
      s1_vs_d <= s1_vs;
    end
  end

  // Largest and smallest of the three S1 channels
  always_comb begin
    max_c = s1_r;
    if (s1_g > max_c) max_c = s1_g;
    if (s1_b > max_c) max_c = s1_b;
    min_c = s1_r;
    if (s1_g < min_c) min_c = s1_g;
    if (s1_b < min_c) min_c = s1_b;
  end

  // S2: weighted products and the alternative reductions. The mode travels
  // with the pixel so S3 selects with the set that was live at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_prod_r <= '0;
      s2_prod_g <= '0;
      s2_prod_b <= '0;
      s2_max    <= '0;
      s2_min    <= '0;
      s2_green  <= '0;
      s2_mode   <= MODE_LUMA;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      s2_de     <= 1'b0;
    end else if (sw_reset) begin
      s2_prod_r <= '0;
      s2_prod_g <= '0;
      s2_prod_b <= '0;
      s2_max    <= '0;
      s2_min    <= '0;
      s2_green  <= '0;
      s2_mode   <= MODE_LUMA;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      s2_de     <= 1'b0;
    end else begin
      s2_prod_r <= PROD_W'(s1_r) * PROD_W'(eff_r);
      s2_prod_g <= PROD_W'(s1_g) * PROD_W'(eff_g);
      s2_prod_b <= PROD_W'(s1_b) * PROD_W'(eff_b);
      s2_max    <= max_c;
      s2_min    <= min_c;
      s2_green  <= s1_g;
      s2_mode   <= eff_mode;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_de     <= s1_de;
    end
  end

  // S3 arithmetic: sum, round to nearest, drop fraction, clamp to channel range
  always_comb begin
    sum_c   = SUM_W'(s2_prod_r) + SUM_W'(s2_prod_g) + SUM_W'(s2_prod_b);
    sum_rnd = {1'b0, sum_c} + RND;
    y_full  = sum_rnd >> FRAC_W;
    y_sat   = (y_full > Y_MAX) ? {CH_W{1'b1}} : y_full[CH_W-1:0];
  end

  // S3 mode selection
  always_comb begin
    sel_c = y_sat;
    case (s2_mode)
      MODE_LUMA:  sel_c = y_sat;
      MODE_MAX:   sel_c = s2_max;
      MODE_MIN:   sel_c = s2_min;
      MODE_GREEN: sel_c = s2_green;
      default:    sel_c = y_sat;
    endcase
  end

  // Channel-width to output-width alignment: keep MSBs or zero-pad LSBs
  generate
    if (OUT_W <= CH_W) begin : g_align_msb
      assign aligned_c = sel_c[CH_W-1 -: OUT_W];
    end else begin : g_align_pad
      assign aligned_c = {sel_c, {(OUT_W-CH_W){1'b0}}};
    end
  endgenerate

  // Final value, gated by active video
  always_comb begin
`ifdef LUMA_BINARIZE_EN
    result_c = (aligned_c >= cfg_thresh) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
`else
    result_c = aligned_c;
`endif
    if (!s2_de) result_c = '0;
  end

  // S3: output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_pData_o  <= '0;
      vid_pHSync_o <= 1'b0;
      vid_pVSync_o <= 1'b0;
      vid_pVDE_o   <= 1'b0;
    end else if (sw_reset) begin
      vid_pData_o  <= '0;
      vid_pHSync_o <= 1'b0;
      vid_pVSync_o <= 1'b0;
      vid_pVDE_o   <= 1'b0;
    end else begin
      vid_pData_o  <= result_c;
      vid_pHSync_o <= s2_hs;
      vid_pVSync_o <= s2_vs;
      vid_pVDE_o   <= s2_de;
    end
  end

endmodule

// File: tb/tb_luma_convert_pipe.sv
// Testbench for luma_convert_pipe (default parameters). Expected output words
// {hsync, vsync, VDE, data} are computed by a behavioural model when each beat
// is driven. They are queued and popped one per clock as the DUT output emerges.
module tb_luma_convert_pipe;

  logic        clk;
  logic        reset;
  logic [23:0] vid_pData_i;
  logic        vid_pHSync_i, vid_pVSync_i, vid_pVDE_i;
  logic [7:0]  vid_pData_o;
  logic        vid_pHSync_o, vid_pVSync_o, vid_pVDE_o;
  logic [8:0]  cfg_coef_r, cfg_coef_g, cfg_coef_b;
  logic [1:0]  cfg_mode;
  logic        cfg_load;
  logic        sw_reset;
  logic        coef_pending;
  logic [15:0] frame_cnt;
`ifdef LUMA_BINARIZE_EN
  logic [7:0]  cfg_thresh;
`endif

  int n_checks;
  int n_fail;

  // Scoreboard: {hs, vs, de, data[7:0]}
  logic [10:0] exp_q[$];

  // Behavioural model of the configuration state
  int m_act_r, m_act_g, m_act_b, m_act_mode;
  int m_pend_r, m_pend_g, m_pend_b, m_pend_mode;
  int m_pending;
  int m_frame;
  logic m_prev_vs;

  luma_convert_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .vid_pData_i  (vid_pData_i),
    .vid_pHSync_i (vid_pHSync_i),
    .vid_pVSync_i (vid_pVSync_i),
    .vid_pVDE_i   (vid_pVDE_i),
    .vid_pData_o  (vid_pData_o),
    .vid_pHSync_o (vid_pHSync_o),
    .vid_pVSync_o (vid_pVSync_o),
    .vid_pVDE_o   (vid_pVDE_o),
    .cfg_coef_r   (cfg_coef_r),
    .cfg_coef_g   (cfg_coef_g),
    .cfg_coef_b   (cfg_coef_b),
    .cfg_mode     (cfg_mode),
    .cfg_load     (cfg_load),
`ifdef LUMA_BINARIZE_EN
    .cfg_thresh   (cfg_thresh),
`endif
    .sw_reset     (sw_reset),
    .coef_pending (coef_pending),
    .frame_cnt    (frame_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pix(input int r, input int g, input int b,
                                           input int md, input int cr, input int cg, input int cb);
    int s, y;
    case (md)
      0: begin
        s = r * cr + g * cg + b * cb;
        y = (s + 128) >> 8;
        if (y > 255) y = 255;
      end
      1: begin
        y = r;
        if (g > y) y = g;
        if (b > y) y = b;
      end
      2: begin
        y = r;
        if (g < y) y = g;
        if (b < y) y = b;
      end
      default: y = g;
    endcase
`ifdef LUMA_BINARIZE_EN
    y = (y >= int'(cfg_thresh)) ? 255 : 0;
`endif
    return 8'(y);
  endfunction

  task automatic model_reset();
    m_act_r = 77;  m_act_g = 150;  m_act_b = 29;  m_act_mode = 0;
    m_pend_r = 77; m_pend_g = 150; m_pend_b = 29; m_pend_mode = 0;
    m_pending = 0;
    m_frame = 0;
    m_prev_vs = 1'b0;
    exp_q.delete();
    // The two pipeline stages behind the output hold zeros after a clear
    exp_q.push_back(11'd0);
    exp_q.push_back(11'd0);
  endtask

  // Drive one beat, predict its output, advance one clock, check the oldest entry
  task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic hs, input logic vs, input logic de, input logic ld);
    logic        rise;
    logic [10:0] e;
    logic [10:0] got;
    vid_pData_i  = {r, g, b};
    vid_pHSync_i = hs;
    vid_pVSync_i = vs;
    vid_pVDE_i   = de;
    cfg_load     = ld;
    if (ld) begin
      m_pend_r = int'(cfg_coef_r); m_pend_g = int'(cfg_coef_g);
      m_pend_b = int'(cfg_coef_b); m_pend_mode = int'(cfg_mode);
      m_pending = 1;
    end
    rise = vs && !m_prev_vs;
    m_prev_vs = vs;
    if (rise) begin
      m_frame = (m_frame + 1) % 65536;
      if (m_pending != 0) begin
        m_act_r = m_pend_r; m_act_g = m_pend_g; m_act_b = m_pend_b;
        m_act_mode = m_pend_mode;
        m_pending = 0;
      end
    end
    e = {hs, vs, de, de ? model_pix(int'(r), int'(g), int'(b), m_act_mode,
                                    m_act_r, m_act_g, m_act_b) : 8'd0};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    got = {vid_pHSync_o, vid_pVSync_o, vid_pVDE_o, vid_pData_o};
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      check("pix", {21'd0, got}, {21'd0, exp_q.pop_front()});
    end
    // Pending flag and frame count lag one clock behind a rise beat
    if (!rise) begin
      check("coef_pending", {31'd0, coef_pending}, m_pending);
      check("frame_cnt", {16'd0, frame_cnt}, m_frame);
    end
  endtask

  task automatic set_cfg(input int cr, input int cg, input int cb, input int md);
    cfg_coef_r = 9'(cr);
    cfg_coef_g = 9'(cg);
    cfg_coef_b = 9'(cb);
    cfg_mode   = 2'(md);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, {24'd0, vid_pData_o}, 32'd0);
    check({tag, "_sync"}, {29'd0, vid_pHSync_o, vid_pVSync_o, vid_pVDE_o}, 32'd0);
  endtask

  // Mid-line asynchronous reset: outputs must clear without a clock edge
  task automatic do_async_reset();
    reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    check("async_rst_frame", {16'd0, frame_cnt}, 32'd0);
    check("async_rst_pending", {31'd0, coef_pending}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Soft clear with a load and a vsync rise on the same beat: the clear wins
  task automatic do_sw_reset();
    set_cfg(1, 2, 3, 2);
    sw_reset     = 1'b1;
    cfg_load     = 1'b1;
    vid_pData_i  = 24'hFFFFFF;
    vid_pHSync_i = 1'b1;
    vid_pVSync_i = 1'b1;
    vid_pVDE_i   = 1'b1;
    @(posedge clk);
    #1;
    sw_reset = 1'b0;
    cfg_load = 1'b0;
    check_outputs_zero("sw_rst");
    check("sw_rst_frame", {16'd0, frame_cnt}, 32'd0);
    check("sw_rst_pending", {31'd0, coef_pending}, 32'd0);
    model_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    sw_reset = 1'b0;
    cfg_load = 1'b0;
    vid_pData_i = '0;
    vid_pHSync_i = 1'b0;
    vid_pVSync_i = 1'b0;
    vid_pVDE_i = 1'b0;
`ifdef LUMA_BINARIZE_EN
    cfg_thresh = 8'd128;
`endif
    set_cfg(77, 150, 29, 0);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_frame", {16'd0, frame_cnt}, 32'd0);
    check("reset_pending", {31'd0, coef_pending}, 32'd0);
    reset = 1'b0;

    // Default weights
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd255, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd0,   8'd0,   8'd255, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd10,  8'd200, 8'd90,  1'b1, 1'b0, 1'b1, 1'b0);
    step(8'd10,  8'd200, 8'd90,  1'b0, 1'b0, 1'b0, 1'b0);

    // Mode 01 loaded mid-frame; pixels keep the old weights until the rise
    set_cfg(77, 150, 29, 1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd0,  8'd0,   8'd0,  1'b0, 1'b0, 1'b0, 1'b0);

    // Mode 10 (min), then mode 11 (green)
    set_cfg(77, 150, 29, 2);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b0);
    set_cfg(77, 150, 29, 3);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b0);

    // Saturation with weights 100/150/50
    set_cfg(100, 150, 50, 0);
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10,  8'd200, 8'd90,  1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 1'b0);

    // Load A before the rise, load B on the beat where the rise is detected
    set_cfg(77, 150, 29, 0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    set_cfg(77, 150, 29, 1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b0);

    // Repeated loads: the last one wins
    set_cfg(77, 150, 29, 2);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b1);
    set_cfg(77, 150, 29, 3);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-line, then defaults again
    do_async_reset();
    step(8'd255, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd10, 8'd200, 8'd90, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd0, 8'd0, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random syncs, pixels and occasional configuration loads
    for (int i = 0; i < 400; i++) begin
      logic ld;
      ld = ($urandom_range(0, 15) == 0);
      if (ld) begin
        set_cfg($urandom_range(0, 511), $urandom_range(0, 511),
                $urandom_range(0, 511), $urandom_range(0, 3));
      end
      step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ld);
    end

    // Soft clear, then a few beats with defaults
    do_sw_reset();
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd10,  8'd200, 8'd90,  1'b0, 1'b0, 1'b1, 1'b0);
    step(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    step(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
